// File: rtl/key_schedule_ctrl_if.sv
// Bundles the start/key request, the round-key stream and the storage read port
// of key_schedule_ctrl into one interface.
interface key_schedule_ctrl_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;

    // Requester side: issues start/key and reads back stored keys
    modport master (
        output start, key_in, rd_idx,
        input  busy, done, rk_valid, rk_out, rk_idx, rd_data
    );

    // Key-schedule side
    modport slave (
        input  start, key_in, rd_idx,
        output busy, done, rk_valid, rk_out, rk_idx, rd_data
    );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule controller.
// Streams round keys 0..NR, one per cycle, from a single combinational
// one-round expansion stage (sub_keyexpansion) fed back through a key register.
// Optional round-key store enabled by defining the macro KS_STORE_EN; without it
// rd_data is tied to zero.

// One AES-128 key-expansion round: next four words from the current four.
module sub_keyexpansion (
    input  logic [127:0] key_in,
    input  logic [3:0]   iter,
    output logic [127:0] key_out
);
    // AES S-box, entry 0 first
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, temp;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  rcon;

    // Round constant for iterations 1..10; out-of-range iterations get zero
    always_comb begin
        rcon = 8'h00;
        case (iter)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    // RotWord then SubWord on the last word, then fold in the round constant
    assign rot  = {w3[23:0], w3[31:24]};
    assign sub  = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
                   sub_byte(rot[15:8]),  sub_byte(rot[7:0])};
    assign temp = sub ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};
endmodule

module key_schedule_ctrl #(
    parameter int unsigned NR = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    key_schedule_ctrl_if.slave  ks
);
    localparam logic [3:0] NrIdx = 4'(NR);

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         rk_valid_q, rk_valid_d;
    logic         done_q, done_d;
    logic [127:0] exp_key;

    sub_keyexpansion u_sub_keyexpansion (
        .key_in  (key_q),
        .iter    (cnt_q),
        .key_out (exp_key)
    );

    // State and stream registers; reset clears everything regardless of state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            key_q      <= '0;
            cnt_q      <= '0;
            rk_out_q   <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            rk_out_q   <= rk_out_d;
            rk_idx_q   <= rk_idx_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: accept in idle, one round per cycle in expand, one done cycle
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        rk_out_d   = rk_out_q;
        rk_idx_d   = rk_idx_q;
        rk_valid_d = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ks.start) begin
                    key_d      = ks.key_in;
                    rk_out_d   = ks.key_in;
                    rk_idx_d   = 4'd0;
                    rk_valid_d = 1'b1;
                    cnt_d      = 4'd1;
                    state_d    = StExpand;
                end
            end
            StExpand: begin
                key_d      = exp_key;
                rk_out_d   = exp_key;
                rk_idx_d   = cnt_q;
                rk_valid_d = 1'b1;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == NrIdx) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // start is deliberately not looked at here; no queuing
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ks.busy     = (state_q != StIdle);
    assign ks.done     = done_q;
    assign ks.rk_valid = rk_valid_q;
    assign ks.rk_out   = rk_out_q;
    assign ks.rk_idx   = rk_idx_q;

`ifdef KS_STORE_EN
    logic [127:0] store_q [0:10];

    // Capture each round key on the same edge it appears on the stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) begin
                store_q[i] <= '0;
            end
        end else if (rk_valid_d) begin
            store_q[rk_idx_d] <= rk_out_d;
        end
    end

    assign ks.rd_data = (ks.rd_idx <= NrIdx) ? store_q[ks.rd_idx] : '0;
`else
    assign ks.rd_data = '0;
`endif
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl: a default NR=10 instance and an NR=4 instance.
module tb_key_schedule_ctrl;
    logic clk;
    logic rst_n;

    key_schedule_ctrl_if ka();
    key_schedule_ctrl_if kb();

    key_schedule_ctrl dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ka)
    );

    key_schedule_ctrl #(.NR(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (kb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] fips_key;
    logic [127:0] fips_rk [0:10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: start one expansion on dut_a and let it run out
    task automatic run_key(input logic [127:0] key);
        ka.key_in = key;
        ka.start  = 1'b1;
        tick();
        ka.start  = 1'b0;
        for (int k = 0; k < 13; k++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (ka.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ka.busy); end
        n_checks++; if (ka.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ka.done); end
        n_checks++; if (ka.rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ka.rk_valid); end
        n_checks++; if (ka.rk_out !== 128'h0) begin n_fail++; $display("FAIL reset_rk_out: got %h want 0", ka.rk_out); end
        n_checks++; if (ka.rk_idx !== 4'd0) begin n_fail++; $display("FAIL reset_rk_idx: got %0d want 0", ka.rk_idx); end
        n_checks++; if (kb.rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: got %b want 0", kb.rk_valid); end
        n_checks++; if (ka.rd_data !== 128'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", ka.rd_data); end
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++; if (ka.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", ka.busy); end
    endtask

    task automatic test_fips();
        int busy_cnt;
        busy_cnt = 0;
        ka.key_in = fips_key;
        ka.start  = 1'b1;
        tick();
        ka.start  = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (ka.busy === 1'b1) busy_cnt++;
            n_checks++; if (ka.rk_valid !== 1'b1) begin n_fail++; $display("FAIL fips_valid[%0d]: got %b want 1", i, ka.rk_valid); end
            n_checks++; if (ka.rk_idx !== 4'(i)) begin n_fail++; $display("FAIL fips_idx[%0d]: got %0d want %0d", i, ka.rk_idx, i); end
            n_checks++; if (ka.rk_out !== fips_rk[i]) begin n_fail++; $display("FAIL fips_rk[%0d]: got %h want %h", i, ka.rk_out, fips_rk[i]); end
            n_checks++; if (ka.done !== (i == 10)) begin n_fail++; $display("FAIL fips_done[%0d]: got %b want %b", i, ka.done, (i == 10)); end
            tick();
        end
        n_checks++; if (busy_cnt != 11) begin n_fail++; $display("FAIL fips_busy_cycles: got %0d want 11", busy_cnt); end
        n_checks++; if (ka.rk_valid !== 1'b0) begin n_fail++; $display("FAIL fips_valid_after: got %b want 0", ka.rk_valid); end
        n_checks++; if (ka.done !== 1'b0) begin n_fail++; $display("FAIL fips_done_after: got %b want 0", ka.done); end
        n_checks++; if (ka.busy !== 1'b0) begin n_fail++; $display("FAIL fips_busy_after: got %b want 0", ka.busy); end
    endtask

    task automatic test_zero_key();
        ka.key_in = 128'h0;
        ka.start  = 1'b1;
        tick();
        ka.start  = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            n_checks++; if (ka.rk_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid[%0d]: got %b want 1", i, ka.rk_valid); end
            if (i == 1) begin
                n_checks++; if (ka.rk_out !== 128'h62636363626363636263636362636363) begin n_fail++; $display("FAIL zero_rk1: got %h want 62636363626363636263636362636363", ka.rk_out); end
            end
            if (i == 10) begin
                n_checks++; if (ka.rk_out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin n_fail++; $display("FAIL zero_rk10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", ka.rk_out); end
                n_checks++; if (ka.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", ka.done); end
            end
            tick();
        end
        n_checks++; if (ka.rk_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid_after: got %b want 0", ka.rk_valid); end
    endtask

    task automatic test_ignore_start();
        int valid_cnt;
        int done_cnt;
        valid_cnt = 0;
        done_cnt  = 0;
        ka.key_in = fips_key;
        ka.start  = 1'b1;
        tick();
        ka.start  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            // Re-request and scramble the key while expanding and in the done cycle
            ka.start  = ((k >= 2 && k <= 6) || k == 10) ? 1'b1 : 1'b0;
            ka.key_in = (k >= 2) ? 128'hdeadbeef_01234567_89abcdef_cafef00d : fips_key;
            if (ka.rk_valid === 1'b1) valid_cnt++;
            if (ka.done === 1'b1) done_cnt++;
            if (k <= 10) begin
                n_checks++; if (ka.rk_out !== fips_rk[k]) begin n_fail++; $display("FAIL ignore_rk[%0d]: got %h want %h", k, ka.rk_out, fips_rk[k]); end
            end
            tick();
        end
        ka.start  = 1'b0;
        ka.key_in = fips_key;
        n_checks++; if (valid_cnt != 11) begin n_fail++; $display("FAIL ignore_valid_cycles: got %0d want 11", valid_cnt); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        ka.key_in = fips_key;
        ka.start  = 1'b1;
        tick();
        ka.start  = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++; if (ka.rk_idx !== 4'd4) begin n_fail++; $display("FAIL mid_idx_before: got %0d want 4", ka.rk_idx); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (ka.rk_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", ka.rk_valid); end
        n_checks++; if (ka.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", ka.busy); end
        n_checks++; if (ka.done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", ka.done); end
        n_checks++; if (ka.rk_out !== 128'h0) begin n_fail++; $display("FAIL mid_rk_out: got %h want 0", ka.rk_out); end
        n_checks++; if (ka.rk_idx !== 4'd0) begin n_fail++; $display("FAIL mid_rk_idx: got %0d want 0", ka.rk_idx); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (ka.rk_valid !== 1'b0 || ka.done !== 1'b0) stray++;
            tick();
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL mid_stray_cycles: got %0d want 0", stray); end
        ka.start = 1'b1;
        tick();
        ka.start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            n_checks++; if (ka.rk_idx !== 4'(i) || ka.rk_out !== fips_rk[i]) begin n_fail++; $display("FAIL mid_rerun[%0d]: got idx %0d rk %h want idx %0d rk %h", i, ka.rk_idx, ka.rk_out, i, fips_rk[i]); end
            if (i == 10) begin
                n_checks++; if (ka.done !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_done: got %b want 1", ka.done); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        ka.key_in = fips_key;
        ka.start  = 1'b1;
        tick();
        for (int k = 0; k <= 10; k++) begin
            n_checks++; if (ka.rk_valid !== 1'b1 || ka.rk_idx !== 4'(k)) begin n_fail++; $display("FAIL b2b_first[%0d]: got valid %b idx %0d want valid 1 idx %0d", k, ka.rk_valid, ka.rk_idx, k); end
            tick();
        end
        // Single idle cycle between runs; swap the key just before it is sampled
        n_checks++; if (ka.rk_valid !== 1'b0 || ka.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got valid %b busy %b want 0 0", ka.rk_valid, ka.busy); end
        ka.key_in = 128'h0;
        tick();
        ka.start  = 1'b0;
        n_checks++; if (ka.rk_valid !== 1'b1 || ka.rk_idx !== 4'd0 || ka.rk_out !== 128'h0) begin n_fail++; $display("FAIL b2b_second0: got valid %b idx %0d rk %h want 1 0 0", ka.rk_valid, ka.rk_idx, ka.rk_out); end
        tick();
        n_checks++; if (ka.rk_out !== 128'h62636363626363636263636362636363) begin n_fail++; $display("FAIL b2b_second1: got %h want 62636363626363636263636362636363", ka.rk_out); end
        for (int k = 2; k <= 11; k++) tick();
        n_checks++; if (ka.rk_valid !== 1'b0 || ka.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got valid %b busy %b want 0 0", ka.rk_valid, ka.busy); end
    endtask

    task automatic test_store();
        run_key(fips_key);
`ifdef KS_STORE_EN
        for (int i = 0; i <= 10; i++) begin
            ka.rd_idx = 4'(i);
            #1;
            n_checks++; if (ka.rd_data !== fips_rk[i]) begin n_fail++; $display("FAIL store_rd[%0d]: got %h want %h", i, ka.rd_data, fips_rk[i]); end
        end
        ka.rd_idx = 4'd15;
        #1;
        n_checks++; if (ka.rd_data !== 128'h0) begin n_fail++; $display("FAIL store_rd15: got %h want 0", ka.rd_data); end
        ka.rd_idx = 4'd11;
        #1;
        n_checks++; if (ka.rd_data !== 128'h0) begin n_fail++; $display("FAIL store_rd11: got %h want 0", ka.rd_data); end
`else
        for (int i = 0; i < 16; i += 5) begin
            ka.rd_idx = 4'(i);
            #1;
            n_checks++; if (ka.rd_data !== 128'h0) begin n_fail++; $display("FAIL nostore_rd[%0d]: got %h want 0", i, ka.rd_data); end
        end
`endif
        ka.rd_idx = 4'd0;
    endtask

    task automatic test_nr4();
        kb.key_in = fips_key;
        kb.start  = 1'b1;
        tick();
        kb.start  = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            n_checks++; if (kb.rk_valid !== 1'b1 || kb.rk_idx !== 4'(i)) begin n_fail++; $display("FAIL nr4_stream[%0d]: got valid %b idx %0d want valid 1 idx %0d", i, kb.rk_valid, kb.rk_idx, i); end
            n_checks++; if (kb.rk_out !== fips_rk[i]) begin n_fail++; $display("FAIL nr4_rk[%0d]: got %h want %h", i, kb.rk_out, fips_rk[i]); end
            n_checks++; if (kb.done !== (i == 4)) begin n_fail++; $display("FAIL nr4_done[%0d]: got %b want %b", i, kb.done, (i == 4)); end
            tick();
        end
        n_checks++; if (kb.rk_valid !== 1'b0 || kb.busy !== 1'b0 || kb.done !== 1'b0) begin n_fail++; $display("FAIL nr4_idle: got valid %b busy %b done %b want 0 0 0", kb.rk_valid, kb.busy, kb.done); end
`ifdef KS_STORE_EN
        kb.rd_idx = 4'd4;
        #1;
        n_checks++; if (kb.rd_data !== fips_rk[4]) begin n_fail++; $display("FAIL nr4_rd4: got %h want %h", kb.rd_data, fips_rk[4]); end
        kb.rd_idx = 4'd5;
        #1;
        n_checks++; if (kb.rd_data !== 128'h0) begin n_fail++; $display("FAIL nr4_rd5: got %h want 0", kb.rd_data); end
        kb.rd_idx = 4'd0;
`endif
    endtask

    initial begin
        fips_key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n     = 1'b0;
        ka.start  = 1'b0;
        ka.key_in = '0;
        ka.rd_idx = '0;
        kb.start  = 1'b0;
        kb.key_in = '0;
        kb.rd_idx = '0;

        test_reset();
        test_fips();
        test_zero_key();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_store();
        test_nr4();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 expansion rounds; legal range 1..10.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to expand key_in; sampled only in IDLE.
REQ-005 SHALL have port key_in, input, 128 bits: cipher key; bits [127:96] are word w0.
REQ-006 SHALL have port busy, output, 1 bit: high in EXPAND and DONE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse, coincident with the round key of index NR.
REQ-008 SHALL have port rk_valid, output, 1 bit: rk_out and rk_idx are valid this cycle.
REQ-009 SHALL have port rk_out, output, 128 bits: streamed round key.
REQ-010 SHALL have port rk_idx, output, 4 bits: round number of rk_out, 0..NR.
REQ-011 SHALL have port rd_idx, input, 4 bits: storage read address.
REQ-012 SHALL have port rd_data, output, 128 bits: stored round key at rd_idx; combinational read.

Function
REQ-013 SHALL use one internal sub_keyexpansion instance.
- in = current key register.
- iter = round counter, 1..NR; rcon(1) = 0x01.
REQ-014 SHALL implement FSM states IDLE, EXPAND and DONE.
REQ-015 In IDLE with start=1, SHALL on the next edge:
- load key_in into the key register.
- set rk_out=key_in, rk_idx=0, rk_valid=1.
- set the round counter to 1.
- enter EXPAND.
REQ-016 In EXPAND, each edge SHALL:
- load the sub_keyexpansion output into the key register and into rk_out.
- set rk_idx to the counter and rk_valid=1.
- increment the counter.
REQ-017 On the EXPAND edge where the counter equals NR, SHALL set done=1 and enter DONE.
REQ-018 In DONE, the next edge SHALL clear done and rk_valid and enter IDLE.
REQ-019 Latency: with start accepted at edge T, round key i SHALL appear after edge T+i for i = 0..NR, and done after edge T+NR.
REQ-020 rk_valid SHALL be high for exactly NR+1 consecutive cycles per expansion and low otherwise.
REQ-021 start in EXPAND or DONE SHALL be ignored, with no queuing.
REQ-022 key_in SHALL be sampled only on the accepting edge; later changes SHALL have no effect.
REQ-023 Back-to-back: start held high SHALL be accepted again on the first IDLE cycle after DONE.

Reset
REQ-024 While rst_n=0, asynchronously and regardless of state:
- state=IDLE.
- busy, done and rk_valid = 0.
- rk_out = 0, rk_idx = 0.
- counter and key register = 0.
REQ-025 Reset mid-expansion SHALL abort; no further rk_valid or done until a new start.
REQ-026 The first start after rst_n rises SHALL behave identically to one from power-up.

Configuration
REQ-027 Macro KS_STORE_EN controls round-key storage.
- Defined: an 11-entry x 128-bit store; entry i is written whenever rk_valid=1 with rk_idx=i. rd_data returns entry rd_idx; 0 when rd_idx > NR. All entries are cleared by reset. Reads during expansion return entries written so far, or older contents.
- Undefined: no storage; rd_data is constant 0; rd_idx is unused; streaming is unchanged.

Verification
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> rk_idx1 = a0fafe1788542cb123a339392a6c7605; rk_idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1 on that cycle; busy high for 11 cycles.
REQ-029 Key all-zero -> rk_idx1 = 62636363626363636263636362636363; rk_idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-030 Start re-pulsed and key_in changed during EXPAND -> stream unchanged, no extra rk_valid cycles, done pulses once.
REQ-031 rst_n low after rk_idx=4 -> all outputs 0 immediately; new start with the FIPS key -> correct full sequence from index 0.
REQ-032 With KS_STORE_EN, after the FIPS run -> rd_idx=0 reads key_in, rd_idx=10 reads d014f9a8..., rd_idx=15 reads 0; without the macro -> rd_data=0 for all rd_idx.
REQ-033 NR=4 build -> rk_valid for 5 cycles, done with rk_idx=4, then IDLE.
